// File: rtl/pool_unit_gen.sv
// pool_unit_gen: a streaming pooling stage with three modes (bypass, signed max,
// rounded/saturated average). Each point arrives as a sequence of channel-group
// vectors. Partial results per group are kept in a register-array accumulator.
// All ports use valid/ready handshakes.
module pool_unit_gen #(
  parameter int VECT_SIZE = 8,
  parameter int WORD_WDT  = 16,
  parameter int ACC_DEPTH = 64,
  parameter int ACC_WDT   = WORD_WDT + 8,
  parameter int PTS_WDT   = 8,
  parameter int CNT_WDT   = 16,
  parameter int GRP_WDT   = $clog2(ACC_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic [1:0]                    cfg_mode,
  input  logic [GRP_WDT-1:0]            cfg_grp_cnt,
  input  logic [PTS_WDT-1:0]            cfg_wind_pts,
  input  logic [CNT_WDT-1:0]            cfg_wind_cnt,
  input  logic [4:0]                    cfg_avg_shift,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  input  logic [VECT_SIZE*WORD_WDT-1:0] in_vect,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [VECT_SIZE*WORD_WDT-1:0] out_vect,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last
);

  localparam int IDX_WDT = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
  localparam int VW      = VECT_SIZE * WORD_WDT;
  localparam int AW      = VECT_SIZE * ACC_WDT;

  localparam logic [GRP_WDT-1:0] ACC_DEPTH_G = GRP_WDT'(ACC_DEPTH);

  // Saturation bounds and rounding unit, one bit wider than the accumulator
  // so that adding the rounding bias cannot wrap.
  localparam logic signed [ACC_WDT:0] SAT_MAX =
    {{(ACC_WDT-WORD_WDT+2){1'b0}}, {(WORD_WDT-1){1'b1}}};
  localparam logic signed [ACC_WDT:0] SAT_MIN =
    {{(ACC_WDT-WORD_WDT+2){1'b1}}, {(WORD_WDT-1){1'b0}}};
  localparam logic signed [ACC_WDT:0] RND_ONE = {{ACC_WDT{1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_RUN} state_e;
  typedef enum logic [1:0] {MODE_BYP = 2'd0, MODE_MAX = 2'd1, MODE_AVG = 2'd2} mode_e;

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [GRP_WDT-1:0] grp_last_q, grp_last_d, grp_idx_q, grp_idx_d;
  logic [PTS_WDT-1:0] pts_last_q, pts_last_d, pt_idx_q, pt_idx_d;
  logic [CNT_WDT-1:0] wind_last_q, wind_last_d, wind_idx_q, wind_idx_d;
  logic [4:0]         shift_q, shift_d;
  logic               fin_q, fin_d;
  logic               cfg_err_q, cfg_err_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [VW-1:0]      out_vect_q, out_vect_d;

  logic [AW-1:0]      acc_q [ACC_DEPTH];
  logic [AW-1:0]      acc_rd;
  logic [AW-1:0]      acc_wr;
  logic [VW-1:0]      lane_out;
  logic [IDX_WDT-1:0] acc_idx;

  logic in_acc, grp_wrap, pt_wrap, wind_wrap, first, job_last;
  logic acc_we, out_load, cfg_ok, cfg_bypass;

  assign cfg_ok = (cfg_mode != 2'd3) && (cfg_grp_cnt != '0) &&
                  (cfg_grp_cnt <= ACC_DEPTH_G) && (cfg_wind_pts != '0) &&
                  (cfg_wind_cnt != '0);
  assign cfg_bypass = (cfg_mode == 2'd0);

  assign in_ready  = (state_q == S_RUN) && !fin_q && (!out_valid_q || out_ready);
  assign in_acc    = in_valid && in_ready;
  assign grp_wrap  = (grp_idx_q == grp_last_q);
  assign pt_wrap   = (pt_idx_q == pts_last_q);
  assign wind_wrap = (wind_idx_q == wind_last_q);
  assign first     = (pt_idx_q == '0);
  assign job_last  = grp_wrap && pt_wrap && wind_wrap;
  assign acc_idx   = grp_idx_q[IDX_WDT-1:0];
  assign acc_rd    = acc_q[acc_idx];
  assign acc_we    = in_acc && (mode_q != MODE_BYP);
  assign out_load  = in_acc && ((mode_q == MODE_BYP) || pt_wrap);

  assign busy      = (state_q == S_RUN);
  assign done      = out_valid_q && out_ready && out_last_q;
  assign cfg_err   = cfg_err_q;
  assign out_vect  = out_vect_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // Per-lane datapath: max/sum update and the rounded, saturated average.
  for (genvar i = 0; i < VECT_SIZE; i++) begin : g_lane
    logic signed [WORD_WDT-1:0] x;
    logic signed [ACC_WDT-1:0]  xs, a, sum, res;
    logic signed [ACC_WDT:0]    rnd, biased, shifted;
    logic [WORD_WDT-1:0]        avg_w;

    assign x      = in_vect[i*WORD_WDT +: WORD_WDT];
    assign xs     = {{(ACC_WDT-WORD_WDT){x[WORD_WDT-1]}}, x};
    assign a      = acc_rd[i*ACC_WDT +: ACC_WDT];
    assign sum    = a + xs;
    assign res    = (mode_q == MODE_MAX) ? ((first || (xs > a)) ? xs : a)
                                         : (first ? xs : sum);
    assign rnd    = (shift_q == 5'd0) ? '0 : (RND_ONE << (shift_q - 5'd1));
    assign biased = {res[ACC_WDT-1], res} + rnd;
    assign shifted = biased >>> shift_q;
    assign avg_w  = (shifted > SAT_MAX) ? SAT_MAX[WORD_WDT-1:0] :
                    (shifted < SAT_MIN) ? SAT_MIN[WORD_WDT-1:0] :
                                          shifted[WORD_WDT-1:0];

    assign acc_wr[i*ACC_WDT +: ACC_WDT] = res;
    assign lane_out[i*WORD_WDT +: WORD_WDT] =
      (mode_q == MODE_AVG) ? avg_w :
      (mode_q == MODE_MAX) ? res[WORD_WDT-1:0] : x;
  end

  // Next-state logic: job start/reject, window counters and the output register.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through this block
    // leaves a signal unassigned and no latch can be inferred.
    state_d     = state_q;
    mode_d      = mode_q;
    grp_last_d  = grp_last_q;
    pts_last_d  = pts_last_q;
    wind_last_d = wind_last_q;
    shift_d     = shift_q;
    grp_idx_d   = grp_idx_q;
    pt_idx_d    = pt_idx_q;
    wind_idx_d  = wind_idx_q;
    fin_d       = fin_q;
    cfg_err_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_vect_d  = out_vect_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_ok) begin
            state_d     = S_RUN;
            mode_d      = mode_e'(cfg_mode);
            grp_last_d  = cfg_bypass ? '0 : cfg_grp_cnt - GRP_WDT'(1);
            pts_last_d  = cfg_bypass ? '0 : cfg_wind_pts - PTS_WDT'(1);
            wind_last_d = cfg_wind_cnt - CNT_WDT'(1);
            shift_d     = cfg_avg_shift;
            grp_idx_d   = '0;
            pt_idx_d    = '0;
            wind_idx_d  = '0;
            fin_d       = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      default: begin
        if (in_acc) begin
          if (grp_wrap) begin
            grp_idx_d = '0;
            if (pt_wrap) begin
              pt_idx_d = '0;
              if (wind_wrap) fin_d = 1'b1;
              else           wind_idx_d = wind_idx_q + CNT_WDT'(1);
            end else begin
              pt_idx_d = pt_idx_q + PTS_WDT'(1);
            end
          end else begin
            grp_idx_d = grp_idx_q + GRP_WDT'(1);
          end
        end
        if (done) state_d = S_IDLE;
      end
    endcase

    // in_ready guarantees the output slot is free whenever a load happens.
    if (out_load) begin
      out_vect_d  = lane_out;
      out_valid_d = 1'b1;
      out_last_d  = job_last;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_BYP;
      grp_last_q  <= '0;
      pts_last_q  <= '0;
      wind_last_q <= '0;
      shift_q     <= '0;
      grp_idx_q   <= '0;
      pt_idx_q    <= '0;
      wind_idx_q  <= '0;
      fin_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_vect_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      mode_q      <= mode_d;
      grp_last_q  <= grp_last_d;
      pts_last_q  <= pts_last_d;
      wind_last_q <= wind_last_d;
      shift_q     <= shift_d;
      grp_idx_q   <= grp_idx_d;
      pt_idx_q    <= pt_idx_d;
      wind_idx_q  <= wind_idx_d;
      fin_q       <= fin_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_vect_q  <= out_vect_d;
    end
  end

  // Accumulator array write on every accepted pooling input.
  always_ff @(posedge clk) begin
    // NOTE: the accumulator has no reset. The first point of every window
    // overwrites its entry, so stale contents are never observed.
    if (acc_we) acc_q[acc_idx] <= acc_wr;
  end

endmodule

// File: tb/tb_pool_unit_gen.sv
// Directed testbench for pool_unit_gen (2 lanes, 4 accumulator entries).
module tb_pool_unit_gen;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [1:0]  cfg_mode;
  logic [2:0]  cfg_grp_cnt;
  logic [7:0]  cfg_wind_pts;
  logic [15:0] cfg_wind_cnt;
  logic [4:0]  cfg_avg_shift;
  logic        busy, done, cfg_err;
  logic [31:0] in_vect;
  logic        in_valid, in_ready;
  logic [31:0] out_vect;
  logic        out_valid, out_ready, out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_vect [$];
  logic        q_last [$];
  logic        q_done [$];

  pool_unit_gen #(.VECT_SIZE(2), .ACC_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_grp_cnt(cfg_grp_cnt), .cfg_wind_pts(cfg_wind_pts),
    .cfg_wind_cnt(cfg_wind_cnt), .cfg_avg_shift(cfg_avg_shift),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_vect(in_vect), .in_valid(in_valid), .in_ready(in_ready),
    .out_vect(out_vect), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every output handshake (values are stable at the falling edge).
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_vect.push_back(out_vect);
      q_last.push_back(out_last);
      q_done.push_back(done);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit exceeded");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int l0, input int l1);
    logic [15:0] a, b;
    a = l0[15:0];
    b = l1[15:0];
    return {b, a};
  endfunction

  task automatic clear_log();
    q_vect.delete();
    q_last.delete();
    q_done.delete();
  endtask

  task automatic start_job(input logic [1:0] mode, input int grp, input int pts,
                           input int wind, input int shift);
    cfg_mode      = mode;
    cfg_grp_cnt   = grp[2:0];
    cfg_wind_pts  = pts[7:0];
    cfg_wind_cnt  = wind[15:0];
    cfg_avg_shift = shift[4:0];
    cfg_start     = 1'b1;
    @(posedge clk); #1;
    cfg_start     = 1'b0;
  endtask

  // Present one vector and hold it until accepted; returns 1 time unit after
  // the accepting edge.
  task automatic send(input int l0, input int l1);
    int n = 0;
    in_vect  = pack(l0, l1);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'(1));
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic stall_out();
    int n = 0;
    logic [31:0] held;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid && n < 500);
    check("bp_first_valid", 32'(out_valid), 32'(1));
    out_ready = 1'b0;
    held = out_vect;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_vect", out_vect, held);
      check("bp_hold_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic run_max(input string tag, input bit stall);
    clear_log();
    start_job(2'd1, 2, 4, 1, 0);
    check({tag, "_busy"}, 32'(busy), 32'(1));
    fork
      begin
        send(0, 2);  send(1, 7);  send(9, -9); send(9, 0);
        send(17, 4); send(3, 0);  send(-1, 0); send(3, -3);
      end
      begin
        if (stall) stall_out();
      end
    join
    wait_done(tag);
    check({tag, "_nout"}, q_vect.size(), 2);
    if (q_vect.size() == 2) begin
      check({tag, "_o0"}, q_vect[0], pack(17, 4));
      check({tag, "_last0"}, 32'(q_last[0]), 32'(0));
      check({tag, "_done0"}, 32'(q_done[0]), 32'(0));
      check({tag, "_o1"}, q_vect[1], pack(9, 7));
      check({tag, "_last1"}, 32'(q_last[1]), 32'(1));
      check({tag, "_done1"}, 32'(q_done[1]), 32'(1));
    end
  endtask

  task automatic run_single(input string tag, input logic [1:0] mode, input int pts,
                            input int shift, input int a0, input int a1,
                            input int b0, input int b1, input logic [31:0] exp);
    clear_log();
    start_job(mode, 1, pts, 1, shift);
    send(a0, a1);
    for (int i = 1; i < pts; i++) send(b0, b1);
    wait_done(tag);
    check({tag, "_nout"}, q_vect.size(), 1);
    if (q_vect.size() == 1) begin
      check({tag, "_o0"}, q_vect[0], exp);
      check({tag, "_last"}, 32'(q_last[0]), 32'(1));
    end
  endtask

  initial begin
    logic [31:0] byp_v [3];
    rst_n = 1'b0; cfg_start = 1'b0; cfg_mode = '0; cfg_grp_cnt = '0;
    cfg_wind_pts = '0; cfg_wind_cnt = '0; cfg_avg_shift = '0;
    in_vect = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_out_vect", out_vect, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Max pool, two groups, four points.
    run_max("max", 1'b0);
    // Same job with a five-cycle output stall.
    run_max("bp", 1'b1);

    // Average: 3+4+4+4=15 -> (15+2)>>2=4; -15 -> (-13)>>>2=-4.
    run_single("avg", 2'd2, 4, 2, 3, -3, 4, -4, pack(4, -4));
    // Average saturation at both limits with no shift.
    run_single("sat", 2'd2, 4, 0, 32767, -32768, 32767, -32768, pack(32767, -32768));

    // Bypass, three vectors with in_valid toggling each cycle.
    clear_log();
    byp_v[0] = pack(5, -6);
    byp_v[1] = pack(100, 200);
    byp_v[2] = pack(-1, 7);
    start_job(2'd0, 2, 3, 3, 0);
    for (int i = 0; i < 3; i++) begin
      in_vect = byp_v[i];
      send(int'($signed(byp_v[i][15:0])), int'($signed(byp_v[i][31:16])));
      check($sformatf("byp_valid%0d", i), 32'(out_valid), 32'(1));
      check($sformatf("byp_vect%0d", i), out_vect, byp_v[i]);
      check($sformatf("byp_last%0d", i), 32'(out_last), 32'(i == 2));
      check($sformatf("byp_done%0d", i), 32'(done), 32'(i == 2));
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
    wait_done("byp");
    check("byp_nout", q_vect.size(), 3);

    // Illegal configurations are rejected with a one-cycle cfg_err.
    start_job(2'd3, 1, 1, 1, 0);
    check("ill_mode_err", 32'(cfg_err), 32'(1));
    check("ill_mode_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    check("ill_mode_err_pulse", 32'(cfg_err), 32'(0));
    start_job(2'd1, 5, 1, 1, 0);
    check("ill_grp_err", 32'(cfg_err), 32'(1));
    check("ill_grp_busy", 32'(busy), 32'(0));
    @(posedge clk); #1;
    check("ill_grp_err_pulse", 32'(cfg_err), 32'(0));
    // Legal job afterwards: max over [5,-1],[-2,8] -> [5,8].
    run_single("legal", 2'd1, 2, 0, 5, -1, -2, 8, pack(5, 8));

    // Reset mid-window, then a fresh job must show no residue.
    clear_log();
    start_job(2'd1, 1, 4, 1, 0);
    send(100, 100);
    send(50, -5);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready", 32'(in_ready), 32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_single("after_rst", 2'd1, 2, 0, -3, -8, -7, -2, pack(-3, -2));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
